// File: rtl/alu_arb_pkg.sv
// Opcode names and FSM state encoding shared by the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_MIN  = 4'hD;
  localparam logic [3:0] OP_MAX  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  localparam logic [7:0] DIV_ZERO_DATA = 8'hFF;
  localparam logic [7:0] DIV_OFF_DATA  = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter; last_q holds the previous winner so a tie goes
// to the other requester. Grants only while en_i is high.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

  // Reset value 1 makes requester 0 the first tie winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last_q <= 1'b1;
    else if (en_i && |req_i)    last_q <= gnt_o[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_DIV_EN to execute divides; otherwise code 4'h3 is rejected.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_op1,
  input  logic [7:0] req0_op2,
  input  logic [3:0] req0_code,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_op1,
  input  logic [7:0] req1_op2,
  input  logic [3:0] req1_code,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic [3:0] alu_code,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic       busy
);

`ifdef ALU_ARB_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Counter is loaded with the remaining cycles after the first EXEC cycle.
  localparam logic [3:0] MULDIV_LAST = 4'(MULDIV_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] op1_q, op2_q;
  logic [3:0] code_q;
  logic       id_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;

  logic [1:0] gnt;
  logic       accept;
  logic [7:0] sel_op1, sel_op2;
  logic [3:0] sel_code;

  alu_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == S_IDLE),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  always_comb begin
    sel_op1  = req0_op1;
    sel_op2  = req0_op2;
    sel_code = req0_code;
    if (gnt[1]) begin
      sel_op1  = req1_op1;
      sel_op2  = req1_op2;
      sel_code = req1_code;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      code_q     <= 4'h0;
      id_q       <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op1_q  <= sel_op1;
            op2_q  <= sel_op2;
            code_q <= sel_code;
            id_q   <= gnt[1];
            if (sel_code == OP_DIV && !DIV_EN) begin
              rsp_data_q <= DIV_OFF_DATA;
              rsp_err_q  <= 1'b1;
              state_q    <= S_RESP;
            end else if (sel_code == OP_DIV && sel_op2 == 8'h00) begin
              rsp_data_q <= DIV_ZERO_DATA;
              rsp_err_q  <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              cnt_q   <= is_muldiv(sel_code) ? MULDIV_LAST : 4'd0;
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q <= alu_out;
            rsp_err_q  <= 1'b0;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_op1   = (state_q == S_EXEC) ? op1_q  : 8'h00;
  assign alu_op2   = (state_q == S_EXEC) ? op2_q  : 8'h00;
  assign alu_code  = (state_q == S_EXEC) ? code_q : 4'h0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, corner sequences and
// randomized transactions against a behavioural model; provides the ALU.
module tb_alu_arbiter;

  localparam int MD = 4;

  typedef struct {
    logic [3:0] code;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } res_t;

  typedef struct {
    string      name;
    bit         id;
    op_t        op;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0] req0_code, req1_code;
  logic [7:0] alu_op1, alu_op2, alu_out;
  logic [3:0] alu_code;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
  logic [7:0] rsp_data;

  int  tests = 0;
  int  fails = 0;
  bit  last_gnt = 1'b1;

  alu_arbiter #(.MULDIV_CYCLES(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_code(req1_code),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_code(alu_code), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[7:0];
      4'h3: return (b == 8'h00) ? 8'hFF : a / b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'h8: return a << b[2:0];
      4'h9: return a >> b[2:0];
      default: return a;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_code, alu_op1, alu_op2);

  // Expected response of a granted operation, straight from the opcode rules.
  function automatic res_t ref_result(input op_t o);
    res_t r;
    r.data = alu_f(o.code, o.a, o.b);
    r.err  = 1'b0;
    r.lat  = (o.code == 4'h2 || o.code == 4'h3) ? MD + 1 : 2;
    if (o.code == 4'h3) begin
`ifdef ALU_ARB_DIV_EN
      if (o.b == 8'h00) begin
        r.data = 8'hFF; r.err = 1'b1; r.lat = 1;
      end
`else
      r.data = 8'h00; r.err = 1'b1; r.lat = 1;
`endif
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.code = $urandom_range(0, 1) ? 4'($urandom_range(2, 3)) : 4'($urandom_range(0, 15));
    o.a    = 8'($urandom_range(0, 255));
    o.b    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy/valid", {busy, rsp_valid}, 2'b00);
    check("reset rsp", {rsp_id, rsp_err, rsp_data}, 10'h0);
    check("reset alu", {alu_op1, alu_op2, alu_code}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1'b1;
  endtask

  // One full transaction: starts and ends just after a negedge in IDLE.
  task automatic txn(input string tag, input bit v0, input bit v1, input op_t o0, input op_t o1,
                     input int hold, input logic [7:0] exp_data, input logic exp_err, input int exp_lat);
    bit         w, alu_bad, stab_bad;
    op_t        o;
    int         lat;
    logic [7:0] d;
    logic       e, id;
    w = (v0 && v1) ? ~last_gnt : v1;
    o = w ? o1 : o0;
    req0_valid = v0; req0_code = o0.code; req0_op1 = o0.a; req0_op2 = o0.b;
    req1_valid = v1; req1_code = o1.code; req1_op1 = o1.a; req1_op2 = o1.b;
    #1;
    check({tag, " grant"}, {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
    @(posedge clk);
    last_gnt = w;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1; alu_bad = 1'b0;
    while (!rsp_valid && lat < 40) begin
      if (alu_op1 !== o.a || alu_op2 !== o.b || alu_code !== o.code || !busy) alu_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, " alu hold"}, alu_bad, 1'b0);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, rsp_data, exp_data);
    check({tag, " err"}, rsp_err, exp_err);
    check({tag, " id"}, rsp_id, w);
    d = rsp_data; e = rsp_err; id = rsp_id;
    req0_valid = 1'b1; req1_valid = 1'b1;
    stab_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      #1;
      if (!rsp_valid || !busy || rsp_data !== d || rsp_err !== e || rsp_id !== id ||
          req0_ready || req1_ready) stab_bad = 1'b1;
      @(negedge clk);
    end
    if (hold > 0) check({tag, " backpressure"}, stab_bad, 1'b0);
    rsp_ready = 1'b1;
    #1;
    check({tag, " exit no grant"}, {rsp_valid, req1_ready, req0_ready}, 3'b100);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    check({tag, " idle"}, {busy, rsp_valid, alu_op1, alu_op2, alu_code}, 22'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    op_t  n0, n1;
    bit   saw, bad;
    int   gq[$];
    int   k;

    tbl[0] = '{"add",     0, '{4'h0, 8'h12, 8'h34}, 0,  8'h46, 1'b0, 2};
    tbl[1] = '{"sub",     1, '{4'h1, 8'h50, 8'h60}, 10, 8'hF0, 1'b0, 2};
    tbl[2] = '{"mul",     0, '{4'h2, 8'h10, 8'h11}, 1,  8'h10, 1'b0, MD + 1};
    tbl[3] = '{"mul ff",  1, '{4'h2, 8'hFF, 8'hFF}, 0,  8'h01, 1'b0, MD + 1};
`ifdef ALU_ARB_DIV_EN
    tbl[4] = '{"div0",    0, '{4'h3, 8'h20, 8'h00}, 2,  8'hFF, 1'b1, 1};
    tbl[5] = '{"div",     1, '{4'h3, 8'h64, 8'h07}, 0,  8'h0E, 1'b0, MD + 1};
`else
    tbl[4] = '{"div0",    0, '{4'h3, 8'h20, 8'h00}, 2,  8'h00, 1'b1, 1};
    tbl[5] = '{"div",     1, '{4'h3, 8'h64, 8'h07}, 0,  8'h00, 1'b1, 1};
`endif
    tbl[6] = '{"and",     0, '{4'h4, 8'hF0, 8'h3C}, 0,  8'h30, 1'b0, 2};
    tbl[7] = '{"xor",     1, '{4'h6, 8'hAA, 8'hFF}, 3,  8'h55, 1'b0, 2};
    tbl[8] = '{"add ovf", 0, '{4'h0, 8'hF0, 8'h20}, 0,  8'h10, 1'b0, 2};

    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op1 = 0; req0_op2 = 0; req0_code = 0;
    req1_op1 = 0; req1_op2 = 0; req1_code = 0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    foreach (tbl[i])
      txn(tbl[i].name, !tbl[i].id, tbl[i].id, tbl[i].op, tbl[i].op, tbl[i].hold,
          tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_lat);

    // Reset in the middle of a multiply: everything clears, no response follows.
    req0_valid = 1'b1; req0_code = 4'h2; req0_op1 = 8'h10; req0_op2 = 8'h11;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid rst rsp", {busy, rsp_valid, rsp_id, rsp_err, rsp_data}, 12'h0);
    check("mid rst alu", {alu_op1, alu_op2, alu_code, req0_ready, req1_ready}, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) saw = 1'b1;
    end
    check("no rsp after rst", saw, 1'b0);
    n0 = '{4'h0, 8'h01, 8'h02};
    n1 = '{4'h0, 8'h10, 8'h20};
    txn("post-rst tie", 1'b1, 1'b1, n0, n1, 0, 8'h03, 1'b0, 2);

    // Contention from reset: grants must alternate starting with requester 0.
    do_reset();
    req0_valid = 1'b1; req0_code = n0.code; req0_op1 = n0.a; req0_op2 = n0.b;
    req1_valid = 1'b1; req1_code = n1.code; req1_op1 = n1.a; req1_op2 = n1.b;
    rsp_ready = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      #1;
      if (req0_ready && req1_ready) bad = 1'b1;
      else if (req0_ready) gq.push_back(0);
      else if (req1_ready) gq.push_back(1);
      if (rsp_valid && rsp_data !== (rsp_id ? 8'h30 : 8'h03)) bad = 1'b1;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont no double/data", bad, 1'b0);
    check("cont grant count", gq.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++)
      check($sformatf("cont grant %0d", i), (i < gq.size()) ? gq[i] : 2, i % 2);
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cont drain", busy, 1'b0);
    rsp_ready = 1'b0;

    do_reset();
    for (int r = 0; r < 30; r++) begin
      int   pat;
      op_t  r0, r1;
      res_t ex;
      bit   w;
      pat = $urandom_range(1, 3);
      r0  = rand_op();
      r1  = rand_op();
      w   = (pat == 3) ? ~last_gnt : (pat == 2);
      ex  = ref_result(w ? r1 : r0);
      txn($sformatf("rnd%0d", r), pat[0], pat[1], r0, r1, $urandom_range(0, 3),
          ex.data, ex.err, ex.lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MULDIV_CYCLES, default 4, EXEC cycles held for codes 4'h2/4'h3 (range 1..15).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  in  1  (N=0,1) requester N has an operation pending.
REQ-005 reqN_ready  out  1  (N=0,1) operation of requester N accepted this cycle.
REQ-006 reqN_op1, reqN_op2  in  8 each  operands of requester N.
REQ-007 reqN_code  in  4  ALU opcode of requester N.
REQ-008 alu_op1, alu_op2  out  8 each  operands driven to the shared ALU.
REQ-009 alu_code  out  4  opcode driven to the shared ALU.
REQ-010 alu_out  in  8  combinational ALU result.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_id  out  1  requester index owning the result.
REQ-013 rsp_data  out  8  result byte.
REQ-014 rsp_err  out  1  operation rejected (divide by zero / division disabled).
REQ-015 rsp_ready  in  1  consumer accepts result.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, RESP.
REQ-018 IDLE: grant = round-robin winner among valid requesters; reqN_ready=1 for the winner only, combinationally, same cycle; ties go to the requester not granted last.
REQ-019 On accept: operands, code and id registered; next state EXEC, or RESP directly for error cases (REQ-023/REQ-029).
REQ-020 alu_op1/op2/code driven from registered values only, stable for all of EXEC; 0 in IDLE.
REQ-021 EXEC length: MULDIV_CYCLES for codes 4'h2, 4'h3; 1 cycle otherwise; a 4-bit down-counter tracks it.
REQ-022 Last EXEC cycle: alu_out captured into rsp_data, rsp_err=0, next RESP; accept-to-rsp_valid latency 2 cycles (simple ops), MULDIV_CYCLES+1 (mul/div).
REQ-023 Code 4'h3 with op2==0: no EXEC, RESP next cycle with rsp_data=8'hFF, rsp_err=1.
REQ-024 RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err held stable until rsp_ready=1; then IDLE next cycle (one bubble, no new grant in the RESP-exit cycle).
REQ-025 reqN_ready=0 outside IDLE; a requester dropping valid before grant is never executed.
REQ-026 rsp_data width truncation: only low 8 bits of any ALU result; no overflow flag.

Reset
REQ-027 rst_n low at any time (including mid-EXEC/RESP): state IDLE, counter 0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, alu_* outputs 0, last-grant pointer=1 (requester 0 wins first); in-flight operation discarded, no response.

Configuration
REQ-028 Macro ALU_ARB_DIV_EN defined: code 4'h3 executed per REQ-021/REQ-023.
REQ-029 Macro ALU_ARB_DIV_EN undefined: code 4'h3 never reaches EXEC; RESP next cycle with rsp_data=8'h00, rsp_err=1; all other codes unaffected.

Structure
REQ-030 Shared package holds opcode constants (4'h0..4'hF names) and FSM state encoding.
REQ-031 One sub-module: alu_rr_arb (2-way round-robin grant with last-grant pointer); the ALU itself stays external.

Verification
REQ-032 Single op: req0 code 4'h0, 8'h12+8'h34 -> accept, rsp_valid 2 cycles later, rsp_data=8'h46, rsp_id=0, rsp_err=0.
REQ-033 Contention: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; no starvation.
REQ-034 Multiply 8'h10*8'h11, MULDIV_CYCLES=4 -> alu_* stable 4 cycles, rsp_data=8'h10 (truncated 0x110), latency 5.
REQ-035 Divide 8'h20/8'h00 -> rsp_err=1, rsp_data=8'hFF with ALU_ARB_DIV_EN; rsp_data=8'h00, rsp_err=1 for any divide without it.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, both reqN_ready=0, busy=1; release -> IDLE next cycle.
REQ-037 rst_n asserted mid-EXEC of a multiply -> all outputs at reset values immediately; no response after release; req0 granted first.
